// File: rtl/game_dumper.sv
// ---------------------------------------------------------------------------
// game_dumper
//
// Reads a loaded cartridge image back out of SDRAM and emits it as an iNES
// byte stream: a 16-byte header, then the PRG body, then the CHR body.
// This is the read-side partner of the ROM loader and feeds the HPS upload
// path while the NES core is held in reset.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse that begins a dump (ignored while busy)
//   abort         synchronous; returns to IDLE at the next edge
//   mapper_flags  [7:0] mapper, [16] mirroring, [18] four-screen
//   prg_pages     number of 16 KB PRG pages
//   chr_pages     number of 8 KB CHR pages (0 = CHR RAM, no CHR body)
//   mem_addr      SDRAM byte read address
//   mem_read      one-cycle read request
//   mem_ack       read data valid (1 or more cycles after mem_read)
//   mem_data      read byte, sampled with mem_ack
//   out_data      stream byte
//   out_valid     stream byte valid
//   out_ready     downstream accepts when out_valid & out_ready
//   busy          high while a dump is in progress
//   done          one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module game_dumper #(
  parameter logic [21:0] CHR_BASE = 22'h200000,
  parameter logic [21:0] PRG_BASE = 22'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] mapper_flags,
  input  logic [7:0]  prg_pages,
  input  logic [7:0]  chr_pages,
  output logic [21:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_PRG_REQ,
    S_PRG_WAIT,
    S_PRG_OUT,
    S_CHR_REQ,
    S_CHR_WAIT,
    S_CHR_OUT,
    S_FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  hdr_idx_reg, hdr_idx_next;
  logic [21:0] offset_reg, offset_next;
  logic [21:0] remaining_reg, remaining_next;
  logic [7:0]  mapper_reg, mapper_next;
  logic        mirroring_reg, mirroring_next;
  logic        four_screen_reg, four_screen_next;
  logic [7:0]  prg_pages_reg, prg_pages_next;
  logic [7:0]  chr_pages_reg, chr_pages_next;
  logic [21:0] mem_addr_reg, mem_addr_next;
  logic        mem_read_reg, mem_read_next;
  logic [7:0]  out_data_reg, out_data_next;
  logic        out_valid_reg, out_valid_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  // Region-entry requests raised inside the state case and applied once
  // after it, so every path into a region sets up counters the same way.
  logic        accept;
  logic        go_prg;
  logic        go_chr;
  logic        go_fin;

  // Only the mapper number and the two nametable bits end up in the header.
  logic        unused_flag_bits;
  assign unused_flag_bits = ^{mapper_flags[31:19], mapper_flags[17], mapper_flags[15:8]};

  // ------------------------------------------------------------------
  // Header bytes, built from the snapshot taken at start.
  // ------------------------------------------------------------------
  logic [7:0] hdr_rom [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_hdr
    if (gi == 0) begin : g_n
      assign hdr_rom[gi] = 8'h4E;
    end else if (gi == 1) begin : g_e
      assign hdr_rom[gi] = 8'h45;
    end else if (gi == 2) begin : g_s
      assign hdr_rom[gi] = 8'h53;
    end else if (gi == 3) begin : g_eof
      assign hdr_rom[gi] = 8'h1A;
    end else if (gi == 4) begin : g_prg
      assign hdr_rom[gi] = prg_pages_reg;
    end else if (gi == 5) begin : g_chr
      assign hdr_rom[gi] = chr_pages_reg;
    end else if (gi == 6) begin : g_flags6
      assign hdr_rom[gi] = {mapper_reg[3:0], four_screen_reg, 2'b00, mirroring_reg};
    end else if (gi == 7) begin : g_flags7
      assign hdr_rom[gi] = {mapper_reg[7:4], 4'h0};
    end else begin : g_pad
      assign hdr_rom[gi] = 8'h00;
    end
  end

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      hdr_idx_reg     <= 4'd0;
      offset_reg      <= 22'd0;
      remaining_reg   <= 22'd0;
      mapper_reg      <= 8'd0;
      mirroring_reg   <= 1'b0;
      four_screen_reg <= 1'b0;
      prg_pages_reg   <= 8'd0;
      chr_pages_reg   <= 8'd0;
      mem_addr_reg    <= 22'd0;
      mem_read_reg    <= 1'b0;
      out_data_reg    <= 8'd0;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hdr_idx_reg     <= hdr_idx_next;
      offset_reg      <= offset_next;
      remaining_reg   <= remaining_next;
      mapper_reg      <= mapper_next;
      mirroring_reg   <= mirroring_next;
      four_screen_reg <= four_screen_next;
      prg_pages_reg   <= prg_pages_next;
      chr_pages_reg   <= chr_pages_next;
      mem_addr_reg    <= mem_addr_next;
      mem_read_reg    <= mem_read_next;
      out_data_reg    <= out_data_next;
      out_valid_reg   <= out_valid_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and output logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    hdr_idx_next     = hdr_idx_reg;
    offset_next      = offset_reg;
    remaining_next   = remaining_reg;
    mapper_next      = mapper_reg;
    mirroring_next   = mirroring_reg;
    four_screen_next = four_screen_reg;
    prg_pages_next   = prg_pages_reg;
    chr_pages_next   = chr_pages_reg;
    mem_addr_next    = mem_addr_reg;
    mem_read_next    = 1'b0;           // read request is always a single pulse
    out_data_next    = out_data_reg;
    out_valid_next   = out_valid_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    accept           = out_valid_reg & out_ready;
    go_prg           = 1'b0;
    go_chr           = 1'b0;
    go_fin           = 1'b0;

    if (abort) begin
      // Abort beats everything, including a coincident start. Any read
      // still in flight is forgotten because WAIT is left behind.
      state_next     = S_IDLE;
      out_valid_next = 1'b0;
      busy_next      = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            mapper_next      = mapper_flags[7:0];
            mirroring_next   = mapper_flags[16];
            four_screen_next = mapper_flags[18];
            prg_pages_next   = prg_pages;
            chr_pages_next   = chr_pages;
            hdr_idx_next     = 4'd0;
            out_data_next    = 8'h4E;      // header byte 0 is fixed
            out_valid_next   = 1'b1;
            busy_next        = 1'b1;
            state_next       = S_HDR;
          end
        end

        S_HDR: begin
          if (accept) begin
            if (hdr_idx_reg == 4'd15) begin
              out_valid_next = 1'b0;
              if (prg_pages_reg != 8'd0) begin
                go_prg = 1'b1;
              end else if (chr_pages_reg != 8'd0) begin
                go_chr = 1'b1;
              end else begin
                go_fin = 1'b1;
              end
            end else begin
              hdr_idx_next  = hdr_idx_reg + 4'd1;
              out_data_next = hdr_rom[hdr_idx_reg + 4'd1];
            end
          end
        end

        S_PRG_REQ: state_next = S_PRG_WAIT;

        S_PRG_WAIT: begin
          if (mem_ack) begin
            out_data_next  = mem_data;
            out_valid_next = 1'b1;
            state_next     = S_PRG_OUT;
          end
        end

        S_PRG_OUT: begin
          if (accept) begin
            out_valid_next = 1'b0;
            offset_next    = offset_reg + 22'd1;
            remaining_next = remaining_reg - 22'd1;
            if (remaining_reg == 22'd1) begin
              if (chr_pages_reg != 8'd0) begin
                go_chr = 1'b1;
              end else begin
                go_fin = 1'b1;
              end
            end else begin
              mem_addr_next = PRG_BASE + offset_reg + 22'd1;
              mem_read_next = 1'b1;
              state_next    = S_PRG_REQ;
            end
          end
        end

        S_CHR_REQ: state_next = S_CHR_WAIT;

        S_CHR_WAIT: begin
          if (mem_ack) begin
            out_data_next  = mem_data;
            out_valid_next = 1'b1;
            state_next     = S_CHR_OUT;
          end
        end

        S_CHR_OUT: begin
          if (accept) begin
            out_valid_next = 1'b0;
            offset_next    = offset_reg + 22'd1;
            remaining_next = remaining_reg - 22'd1;
            if (remaining_reg == 22'd1) begin
              go_fin = 1'b1;
            end else begin
              mem_addr_next = CHR_BASE + offset_reg + 22'd1;
              mem_read_next = 1'b1;
              state_next    = S_CHR_REQ;
            end
          end
        end

        S_FIN: state_next = S_IDLE;

        default: begin
          state_next     = S_IDLE;
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
        end
      endcase

      // The first read of a region is issued on entry, so mem_read is high
      // for the whole REQ cycle and the byte period can be 3 cycles.
      if (go_prg) begin
        offset_next    = 22'd0;
        remaining_next = {prg_pages_reg, 14'b0};
        mem_addr_next  = PRG_BASE;
        mem_read_next  = 1'b1;
        state_next     = S_PRG_REQ;
      end
      if (go_chr) begin
        offset_next    = 22'd0;
        remaining_next = {1'b0, chr_pages_reg, 13'b0};
        mem_addr_next  = CHR_BASE;
        mem_read_next  = 1'b1;
        state_next     = S_CHR_REQ;
      end
      if (go_fin) begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_FIN;
      end
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_read  = mem_read_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: doc/game_dumper.md
Name: game_dumper

Overview:
- Streams a loaded cartridge image back out of SDRAM as a well-formed iNES byte stream: a 16-byte header, then the PRG body, then the CHR body.
- It is the read-side counterpart of the ROM loader and is used for ROM upload/dump to the HPS.
- It sits between the SDRAM CPU port (while the NES is held in reset) and the HPS upload path.

Parameters:
- CHR_BASE, 22'h200000, SDRAM byte address where the CHR region starts.
- PRG_BASE, 22'h000000, SDRAM byte address where the PRG region starts.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a dump; ignored while busy=1.
- abort  in  1  synchronous; returns the block to IDLE at the next edge and drops any pending read.
- mapper_flags  in  32  active mapper flags: [7:0] mapper, [16] mirroring, [18] four-screen.
- prg_pages  in  8  number of 16 KB PRG pages.
- chr_pages  in  8  number of 8 KB CHR pages; 0 means CHR RAM, so no CHR body is emitted.
- mem_addr  out  22  byte read address.
- mem_read  out  1  single-cycle read request.
- mem_ack  in  1  read data valid; arrives 1 or more cycles after mem_read.
- mem_data  in  8  read byte, sampled when mem_ack=1.
- out_data  out  8  stream byte.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accepts the byte when out_valid=1 and out_ready=1.
- busy  out  1  high from the cycle after start until done is asserted.
- done  out  1  single-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values: state=IDLE, mem_addr=0, mem_read=0, out_data=0, out_valid=0, busy=0, done=0.
- Parameter snapshot: on start, latch mapper_flags, prg_pages and chr_pages. Later input changes have no effect on a dump in progress.
- State machine: IDLE -> HDR -> PRG_REQ <-> PRG_WAIT <-> PRG_OUT -> CHR_REQ <-> CHR_WAIT <-> CHR_OUT -> FIN -> IDLE.
- Header content (bytes 0..15):
  - Bytes 0..3: 4E 45 53 1A.
  - Byte 4: prg_pages.
  - Byte 5: chr_pages.
  - Byte 6: {mapper[3:0], four_screen, 1'b0, 1'b0, mirroring}.
  - Byte 7: {mapper[7:4], 4'b0000}.
  - Bytes 8..15: 00.
- HDR: a 4-bit index steps through the header, one byte per handshake. After byte 15 is accepted, go to PRG_REQ, or to CHR_REQ if prg_pages=0.
- Byte counters:
  - PRG remaining = {prg_pages, 14'b0}. The count is 22 bits wide; 255 pages = 0x3FC000.
  - CHR remaining = {1'b0, chr_pages, 13'b0}.
- Read sequence:
  - *_REQ: drive mem_addr = base + offset and pulse mem_read for exactly one cycle, then go to *_WAIT.
  - *_WAIT: on mem_ack, register mem_data into out_data, set out_valid, go to *_OUT.
  - At most one read is outstanding. mem_ack outside *_WAIT is ignored.
- *_OUT:
  - Hold out_data and out_valid stable until out_ready=1.
  - On acceptance, drop out_valid (unless the next byte is already registered), increment the offset and decrement remaining.
  - If remaining becomes 0, leave the region: PRG goes to CHR_REQ (or FIN if chr_pages=0); CHR goes to FIN.
  - Otherwise return to *_REQ.
- Bubbles: the minimum per-byte period is 3 cycles (REQ, WAIT with ack, OUT with ready). Bubbles are allowed between bytes; out_valid must never deassert without a handshake.
- FIN: pulse done for one cycle, clear busy, return to IDLE.
- Empty image: prg_pages=0 and chr_pages=0 produces a 16-byte header only, followed by done.
- Simultaneous start and abort: abort wins and the block stays in IDLE.
- Reset or abort mid-dump: out_valid=0 and mem_read=0 immediately. A late mem_ack is ignored, and no done pulse is issued.
- Address wrap: addresses never wrap. The maximum PRG end address is 0x3FBFFF, and base+offset uses 22-bit arithmetic.

Test Plan:
- prg_pages=1, chr_pages=1, mapper_flags=0x00010004, mem_ack 1 cycle after mem_read, out_ready=1 -> header 4E 45 53 1A 01 01 41 00 00x8; 16384 reads at 0x000000..0x003FFF; then 8192 reads at 0x200000..0x201FFF; exactly 24592 bytes; a single done pulse.
- prg_pages=2, chr_pages=0, mapper=0x42 -> header bytes 4=02, 5=00, 6=0x20, 7=0x40; 32768 PRG bytes; no address ≥0x200000 ever issued.
- out_ready toggled randomly and mem_ack delayed 0..5 cycles -> stream byte-identical to the model; out_data stable whenever out_valid=1 and out_ready=0; never more than one read outstanding.
- abort asserted after 100 PRG bytes, with a late mem_ack 2 cycles later -> IDLE, out_valid=0, busy=0, no done pulse. A subsequent start dumps the full image from the header again.
- prg_pages=0, chr_pages=0 -> 16 header bytes, zero mem_read pulses, done on the cycle after the last header byte is accepted. A start pulse while busy has no effect.
- reset asserted asynchronously mid-CHR -> all outputs return to their reset values within the same cycle.
